// File: rtl/motor_seq_pkg.sv
// Shared types and default constants for the motor drive sequencer.
// State encoding is exposed on state_out for the debug LEDs.
package motor_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_DEADTIME = 3'd2,
      ST_BRAKE    = 3'd3,
      ST_HOLD     = 3'd4,
      ST_FAULT    = 3'd5
   } state_e;

   localparam int DEF_CMD_MAX          = 200;
   localparam int DEF_RAMP_STEP_CYCLES = 50000;
   localparam int DEF_DEADTIME_CYCLES  = 100000;
   localparam int DEF_BRAKE_CYCLES     = 200000;
   localparam int DEF_TEMP_W           = 13;
   localparam int DEF_TEMP_HI          = 1120;
   localparam int DEF_TEMP_LO          = 960;
   localparam int DEF_TEMP_TRIP        = 1360;

   // Derated duty limit is CMD_MAX shifted right by this amount.
   localparam int DERATE_SHIFT = 1;

   // Width of a counter running 0..n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/temp_guard.sv
// Thermal guard: hysteretic derate flag and a same-cycle trip strobe,
// both evaluated only when a fresh signed temperature word is strobed in.
module temp_guard
   import motor_seq_pkg::*;
#(
   parameter int TEMP_W    = DEF_TEMP_W,
   parameter int TEMP_HI   = DEF_TEMP_HI,
   parameter int TEMP_LO   = DEF_TEMP_LO,
   parameter int TEMP_TRIP = DEF_TEMP_TRIP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TEMP_W-1:0] temp_data,
   input  logic              temp_valid,
   output logic              derate,
   output logic              trip
);

   localparam logic signed [TEMP_W-1:0] HI_S   = TEMP_W'(TEMP_HI);
   localparam logic signed [TEMP_W-1:0] LO_S   = TEMP_W'(TEMP_LO);
   localparam logic signed [TEMP_W-1:0] TRIP_S = TEMP_W'(TEMP_TRIP);

   logic signed [TEMP_W-1:0] temp_s;
   logic                     derate_q, derate_d;

   always_comb begin
      temp_s   = temp_data;
      derate_d = derate_q;
      // Readings strictly between the thresholds keep the current state.
      if (temp_valid) begin
         if (temp_s >= HI_S)
            derate_d = 1'b1;
         else if (temp_s <= LO_S)
            derate_d = 1'b0;
      end
      trip = temp_valid && (temp_s >= TRIP_S);
   end

   always_ff @(posedge clk) begin
      if (reset)
         derate_q <= 1'b0;
      else
         derate_q <= derate_d;
   end

   assign derate = derate_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// Sequences duty/direction changes for both motor PWM generators: ramp,
// reversal dead-time, endstop brake and thermal derate/trip.
// Define MOTOR_SEQ_RAMP_EN for tick-paced ramping; otherwise duty follows target next cycle.
module motor_drive_sequencer
   import motor_seq_pkg::*;
#(
   parameter int CMD_MAX          = DEF_CMD_MAX,
   parameter int DUTY_W           = 8,
   parameter int RAMP_STEP_CYCLES = DEF_RAMP_STEP_CYCLES,
   parameter int DEADTIME_CYCLES  = DEF_DEADTIME_CYCLES,
   parameter int BRAKE_CYCLES     = DEF_BRAKE_CYCLES,
   parameter int TEMP_W           = DEF_TEMP_W,
   parameter int TEMP_HI          = DEF_TEMP_HI,
   parameter int TEMP_LO          = DEF_TEMP_LO,
   parameter int TEMP_TRIP        = DEF_TEMP_TRIP
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DUTY_W-1:0] cmd_duty,
   input  logic              cmd_dir,
   input  logic              reed_in,
   input  logic [TEMP_W-1:0] temp_data,
   input  logic              temp_valid,
   output logic [DUTY_W-1:0] duty_out,
   output logic              dir_out,
   output logic              brake_out,
   output logic              derate,
   output logic              fault,
   output logic [2:0]        state_out
);

   // One counter times dead-time, brake and ramp steps; those states never overlap.
   localparam int CNT_SPAN0 = (DEADTIME_CYCLES > BRAKE_CYCLES) ? DEADTIME_CYCLES : BRAKE_CYCLES;
   localparam int CNT_SPAN  = (RAMP_STEP_CYCLES > CNT_SPAN0) ? RAMP_STEP_CYCLES : CNT_SPAN0;
   localparam int CNT_W     = cnt_w(CNT_SPAN);

   localparam logic [DUTY_W-1:0] LIM_FULL   = DUTY_W'(CMD_MAX);
   localparam logic [DUTY_W-1:0] LIM_DER    = DUTY_W'(CMD_MAX >> DERATE_SHIFT);
   localparam logic [CNT_W-1:0]  DEAD_LAST  = CNT_W'(DEADTIME_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
`ifdef MOTOR_SEQ_RAMP_EN
   localparam logic [CNT_W-1:0]  STEP_LAST  = CNT_W'(RAMP_STEP_CYCLES - 1);
   logic [DUTY_W-1:0] duty_step;
`endif

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              dir_q, dir_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              reed_prev_q;
   logic              trip, reed_rise;
   logic [DUTY_W-1:0] lim, target, eff_target;

   temp_guard #(
      .TEMP_W    (TEMP_W),
      .TEMP_HI   (TEMP_HI),
      .TEMP_LO   (TEMP_LO),
      .TEMP_TRIP (TEMP_TRIP)
   ) u_temp_guard (
      .clk        (clk),
      .reset      (reset),
      .temp_data  (temp_data),
      .temp_valid (temp_valid),
      .derate     (derate),
      .trip       (trip)
   );

   always_comb begin
      lim        = derate ? LIM_DER : LIM_FULL;
      target     = (cmd_duty > lim) ? lim : cmd_duty;
      eff_target = (cmd_dir != dir_q) ? '0 : target;
      reed_rise  = reed_in & ~reed_prev_q;
`ifdef MOTOR_SEQ_RAMP_EN
      if (duty_q < eff_target)
         duty_step = duty_q + DUTY_W'(1);
      else if (duty_q > eff_target)
         duty_step = duty_q - DUTY_W'(1);
      else
         duty_step = duty_q;
`endif
   end

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            duty_d = '0;
            if (enable && (target != '0) && !reed_in) begin
               dir_d   = cmd_dir;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (reed_rise) begin
               duty_d  = '0;
               cnt_d   = '0;
               state_d = ST_BRAKE;
            end else if (!enable) begin
               duty_d  = '0;
               state_d = ST_IDLE;
            end else if ((duty_q == '0) && (cmd_dir != dir_q)) begin
               cnt_d   = '0;
               state_d = ST_DEADTIME;
            end else if ((duty_q == '0) && (target == '0)) begin
               state_d = ST_IDLE;
            end else begin
`ifdef MOTOR_SEQ_RAMP_EN
               // Over-limit duty after a derate also walks down here, one count per tick.
               if (cnt_q == STEP_LAST) begin
                  cnt_d  = '0;
                  duty_d = duty_step;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`else
               duty_d = eff_target;
`endif
            end
         end
         ST_DEADTIME: begin
            duty_d = '0;
            if (reed_rise) begin
               cnt_d   = '0;
               state_d = ST_BRAKE;
            end else if (!enable) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DEAD_LAST) begin
               dir_d   = cmd_dir;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BRAKE: begin
            duty_d = '0;
            if (cnt_q == BRAKE_LAST)
               state_d = ST_HOLD;
            else
               cnt_d = cnt_q + CNT_W'(1);
         end
         ST_HOLD: begin
            duty_d = '0;
            if ((cmd_duty == '0) && !reed_in)
               state_d = ST_IDLE;
         end
         ST_FAULT: begin
            duty_d = '0;
         end
         default: begin
            duty_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
      if (trip) begin
         duty_d  = '0;
         state_d = ST_FAULT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         duty_q      <= '0;
         dir_q       <= 1'b1;
         cnt_q       <= '0;
         reed_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         reed_prev_q <= reed_in;
      end
   end

   assign duty_out  = duty_q;
   assign dir_out   = dir_q;
   assign brake_out = (state_q == ST_BRAKE) || (state_q == ST_FAULT);
   assign fault     = (state_q == ST_FAULT);
   assign state_out = state_q;

endmodule
